div_sequencer: RTL and testbench

- Multi-cycle sequencer for MIPS DIV/DIVU, launched from the execute stage.
- Runs a radix-2 restoring divide over 32 iterations and holds the pipeline via a stall request while it runs.
- Presents quotient (LO) and remainder (HI) with a one-cycle ready pulse.
- Sits beside the execute ALU; execute drives start/operands and consumes results on ready.

---
 rtl/div_sequencer_pkg.sv | 22 ++
 rtl/div_sequencer_step.sv | 23 ++
 rtl/div_sequencer.sv | 174 +++++++++++++++++
 tb/tb_div_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the divide sequencer: state encodings, the
// iteration count and the execute-stage ALU op codes for DIV/DIVU.
package div_sequencer_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE   = 2'd0,
    DIV_BYZERO = 2'd1,
    DIV_ON     = 2'd2,
    DIV_END    = 2'd3
  } divState_e;

  localparam int DIV_CYCLES = 32;

  // MIPS funct codes execute decodes to raise start_i / signed_i
  localparam logic [5:0] ALUOP_DIV  = 6'b011010;
  localparam logic [5:0] ALUOP_DIVU = 6'b011011;

  function automatic logic isDivOp(input logic [5:0] aluOp);
    return (aluOp == ALUOP_DIV) || (aluOp == ALUOP_DIVU);
  endfunction

endpackage

// File: rtl/div_sequencer_step.sv
// One radix-2 restoring divide step: shift the next dividend bit into the
// partial remainder and subtract the divisor if it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] partRem_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             nextBit_i,
  output logic [WIDTH-1:0] newRem_o,
  output logic             quoBit_o
);

  logic [WIDTH-1:0] shiftedLow;

  // The bit shifted out of the remainder top means the trial value already
  // exceeds any WIDTH-bit divisor, so the subtraction always succeeds then.
  always_comb begin
    shiftedLow = {partRem_i[WIDTH-2:0], nextBit_i};
    quoBit_o   = partRem_i[WIDTH-1] | (shiftedLow >= divisor_i);
    newRem_o   = quoBit_o ? (shiftedLow - divisor_i) : shiftedLow;
  end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU sequencer beside the execute ALU. Runs a restoring
// divide over WIDTH iterations, stalls the pipeline while busy and pulses
// ready_o for one cycle with quotient (LO) and remainder (HI).
// Optional early-out for |dividend| < |divisor|: define DIV_EARLY_OUT_EN.
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int WIDTH = DIV_CYCLES,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             annul_i,
  output logic             stall_req_o,
  output logic             ready_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  divState_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] rawDvd_q, rawDvd_d;
  logic             negQuo_q, negQuo_d;
  logic             negRem_q, negRem_d;
  logic             earlyOut_q, earlyOut_d;
  logic             ready_q, ready_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;

  logic             dvdNeg, dvsNeg;
  logic [WIDTH-1:0] dvdAbs, dvsAbs;
  logic             earlyHit;
  logic [WIDTH-1:0] stepRem;
  logic             stepBit;
  logic [WIDTH-1:0] finalQuo;

  div_step #(.WIDTH(WIDTH)) u_step (
    .partRem_i (rem_q),
    .divisor_i (dvsr_q),
    .nextBit_i (quo_q[WIDTH-1]),
    .newRem_o  (stepRem),
    .quoBit_o  (stepBit)
  );

  // Operand magnitudes and sign flags, only meaningful for signed DIV
  always_comb begin
    dvdNeg   = signed_i & dividend_i[WIDTH-1];
    dvsNeg   = signed_i & divisor_i[WIDTH-1];
    dvdAbs   = dvdNeg ? -dividend_i : dividend_i;
    dvsAbs   = dvsNeg ? -divisor_i : divisor_i;
    finalQuo = {quo_q[WIDTH-2:0], stepBit};
  end

`ifdef DIV_EARLY_OUT_EN
  assign earlyHit = (dvdAbs < dvsAbs);
`else
  assign earlyHit = 1'b0;
`endif

  // Next-state and datapath updates; results are loaded on the way into END
  // so the registered outputs are already valid in the ready cycle
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvsr_d      = dvsr_q;
    rawDvd_d    = rawDvd_q;
    negQuo_d    = negQuo_q;
    negRem_d    = negRem_q;
    earlyOut_d  = earlyOut_q;
    ready_d     = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    case (state_q)
      DIV_IDLE: begin
        if (start_i && !annul_i) begin
          rawDvd_d = dividend_i;
          if (divisor_i == '0) begin
            earlyOut_d = 1'b0;
            state_d    = DIV_BYZERO;
          end else if (earlyHit) begin
            // early-out shares the one-cycle hold state to keep its latency
            earlyOut_d = 1'b1;
            state_d    = DIV_BYZERO;
          end else begin
            rem_d    = '0;
            quo_d    = dvdAbs;
            dvsr_d   = dvsAbs;
            negQuo_d = dvdNeg ^ dvsNeg;
            negRem_d = dvdNeg;
            cnt_d    = '0;
            state_d  = DIV_ON;
          end
        end
      end
      DIV_BYZERO: begin
        if (annul_i) begin
          state_d = DIV_IDLE;
        end else begin
          state_d     = DIV_END;
          ready_d     = 1'b1;
          quotient_d  = earlyOut_q ? '0 : '1;
          remainder_d = rawDvd_q;
        end
      end
      DIV_ON: begin
        if (annul_i) begin
          state_d = DIV_IDLE;
        end else begin
          rem_d = stepRem;
          quo_d = finalQuo;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d     = DIV_END;
            ready_d     = 1'b1;
            quotient_d  = negQuo_q ? -finalQuo : finalQuo;
            remainder_d = negRem_q ? -stepRem : stepRem;
          end
        end
      end
      DIV_END: begin
        state_d = DIV_IDLE;
      end
      default: begin
        state_d = DIV_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= DIV_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      rawDvd_q    <= '0;
      negQuo_q    <= 1'b0;
      negRem_q    <= 1'b0;
      earlyOut_q  <= 1'b0;
      ready_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvsr_q      <= dvsr_d;
      rawDvd_q    <= rawDvd_d;
      negQuo_q    <= negQuo_d;
      negRem_q    <= negRem_d;
      earlyOut_q  <= earlyOut_d;
      ready_q     <= ready_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  assign stall_req_o = start_i & ~ready_q & ~annul_i;
  assign ready_o     = ready_q;
  assign quotient_o  = quotient_q;
  assign remainder_o = remainder_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: stimulus pushes expected results
// from an arithmetic reference model into a scoreboard; a monitor pops and
// compares whenever ready_o is seen.
module tb_div_sequencer;

  localparam int BOUND     = 80;
  localparam int ANNUL_CYC = 10;
  localparam int RESET_CYC = 15;

  typedef struct {
    logic [31:0] quo;
    logic [31:0] rem;
    int          startCyc;
    int          lat;
  } expect_t;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        signed_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic        annul_i;
  logic        stall_req_o;
  logic        ready_o;
  logic [31:0] quotient_o;
  logic [31:0] remainder_o;

  expect_t sbQ[$];
  expect_t monE;
  int      cycleCount = 0;
  int      checkCount = 0;
  int      passCount  = 0;

  div_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .signed_i    (signed_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .annul_i     (annul_i),
    .stall_req_o (stall_req_o),
    .ready_o     (ready_o),
    .quotient_o  (quotient_o),
    .remainder_o (remainder_o)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used to measure latency
  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
  endtask

  // Reference divide from plain 64-bit arithmetic; truncating division gives
  // the MIPS quotient/remainder sign rules and the overflow wrap for free
  function automatic void modelDivide(input logic s, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] q, output logic [31:0] r, output int lat);
    longint sa, sb, magA, magB;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      lat = 2;
      return;
    end
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = 32'(sa / sb);
    r = 32'(sa % sb);
    magA = (sa < 0) ? -sa : sa;
    magB = (sb < 0) ? -sb : sb;
    lat = 33;
`ifdef DIV_EARLY_OUT_EN
    if (magA < magB) lat = 2;
`else
    if (magA < magB) lat = 33;
`endif
  endfunction

  // Monitor: every ready pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    #1;
    if (ready_o === 1'b1) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpected_ready", 32'd1, 32'd0);
      end else begin
        monE = sbQ.pop_front();
        checkOutput("quotient", quotient_o, monE.quo);
        checkOutput("remainder", remainder_o, monE.rem);
        checkOutput("latency", 32'(cycleCount - monE.startCyc), 32'(monE.lat));
      end
    end
  end

  // Issue one divide; abortMode 1 annuls at ANNUL_CYC, 2 resets mid-run
  task automatic applyStimulus(input logic isSigned, input logic [31:0] a, input logic [31:0] b,
                               input int abortMode);
    expect_t e;
    int      stallBad;
    bit      readySeen;
    bit      aborted;
    modelDivide(isSigned, a, b, e.quo, e.rem, e.lat);
    @(negedge clk);
    signed_i   = isSigned;
    dividend_i = a;
    divisor_i  = b;
    annul_i    = 1'b0;
    start_i    = 1'b1;
    e.startCyc = cycleCount;
    if (abortMode == 0) sbQ.push_back(e);
    stallBad  = 0;
    readySeen = 0;
    aborted   = 0;
    for (int c = 0; c < BOUND && !readySeen && !aborted; c++) begin
      #1;
      if (ready_o === 1'b1) begin
        checkOutput("stall_in_ready_cycle", 32'(stall_req_o), 32'd0);
        readySeen = 1;
        start_i   = 1'b0;
      end else if (abortMode == 1 && c == ANNUL_CYC + 1) begin
        checkOutput("annul_stall", 32'(stall_req_o), 32'd0);
        start_i = 1'b0;
        annul_i = 1'b0;
        aborted = 1;
      end else begin
        if (stall_req_o !== 1'b1) stallBad++;
        if (abortMode == 1 && c == ANNUL_CYC) annul_i = 1'b1;
        if (abortMode == 2 && c == RESET_CYC) begin
          #1 rst = 1'b1;
          #1;
          checkOutput("rst_ready", 32'(ready_o), 32'd0);
          checkOutput("rst_quotient", quotient_o, 32'd0);
          checkOutput("rst_remainder", remainder_o, 32'd0);
          start_i = 1'b0;
          aborted = 1;
        end
      end
      if (!readySeen && !aborted) @(negedge clk);
    end
    checkOutput("stall_hold", 32'(stallBad), 32'd0);
    if (abortMode == 0 && !readySeen) begin
      checkOutput("ready_timeout", 32'd0, 32'd1);
      start_i = 1'b0;
      if (sbQ.size() > 0) void'(sbQ.pop_front());
    end
    if (abortMode == 2) begin
      @(negedge clk);
      rst = 1'b0;
    end
  endtask

  // Directed cases from the plan, then randomized operations
  initial begin
    logic        rs;
    logic [31:0] ra, rb;
    rst        = 1'b1;
    start_i    = 1'b0;
    signed_i   = 1'b0;
    dividend_i = 32'd0;
    divisor_i  = 32'd0;
    annul_i    = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_ready", 32'(ready_o), 32'd0);
    checkOutput("reset_quotient", quotient_o, 32'd0);
    checkOutput("reset_remainder", remainder_o, 32'd0);
    checkOutput("reset_stall", 32'(stall_req_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(1'b0, 32'd100, 32'd7, 0);
    applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    applyStimulus(1'b0, 32'hFFFF_FFF9, 32'd2, 0);
    applyStimulus(1'b0, 32'h0000_1234, 32'd0, 0);
    applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    applyStimulus(1'b0, 32'd1000, 32'd3, 1);
    applyStimulus(1'b0, 32'd50, 32'd5, 0);
    applyStimulus(1'b0, 32'd123456, 32'd7, 2);
    applyStimulus(1'b0, 32'd9, 32'd4, 0);
    applyStimulus(1'b0, 32'd3, 32'd8, 0);
    applyStimulus(1'b1, 32'hFFFF_FFFD, 32'd8, 0);

    for (int i = 0; i < 24; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = $urandom;
        1: rb = 32'($urandom_range(1, 100));
        2: rb = 32'($urandom_range(0, 3));
        default: rb = -32'($urandom_range(1, 20));
      endcase
      applyStimulus(rs, ra, rb, 0);
    end

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(sbQ.size()), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
